seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Hex display controller for a bank of seven-segment digits. A captured copy of
// the input value is decoded to segment patterns (with optional leading-zero
// blanking) and presented two ways:
//   * multiplexed: one digit at a time on seg/an, each digit owning a slot of
//     SCAN_DIV clocks whose first BLANK_CYC clocks are dark to suppress ghosting
//   * static: every digit at once on segs_all
//
// Parameters
//   DIGITS      number of hex digits (1..16)
//   SCAN_DIV    clocks per digit slot (>= 4)
//   BLANK_CYC   dark clocks at the start of each slot (< SCAN_DIV)
//   ACTIVE_LOW  1: seg, an and segs_all are inverted at the pins
//
// Ports
//   clk         clock, all state on rising edge
//   clr         asynchronous active-high reset
//   value       4*DIGITS nibbles, digit 0 in the least significant nibble
//   load        capture strobe for value
//   hold        freezes the captured value while high
//   blank_lz    leading-zero blanking enable
//   seg         scanned segments {g,f,e,d,c,b,a}, registered
//   an          one-hot digit enable, registered
//   segs_all    static segments, digit k at [7k+6:7k], registered
//   frame_done  one-clock pulse after the last slot of a frame (never inverted)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 1024,
  parameter int BLANK_CYC  = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  hold,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [7*DIGITS-1:0]   segs_all,
  output logic                  frame_done
);

  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [SC_W-1:0]  SC_BLANK = SC_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Inactive pin levels. Polarity is applied by XOR with these masks, so the
  // same constant doubles as the reset value of each output register.
  localparam logic [6:0]          SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0]   AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7*DIGITS-1:0] ALL_OFF = ACTIVE_LOW ? {(7*DIGITS){1'b1}} : {(7*DIGITS){1'b0}};

  // Active-high hex to {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] cap_q, cap_d;
  logic [SC_W-1:0]     sc_q, sc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                frame_q, frame_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7*DIGITS-1:0] all_q, all_d;

  logic                sc_wrap;
  logic [IDX_W-1:0]    top_nz;
  logic [7*DIGITS-1:0] dec_all;
  logic [6:0]          dig_sel;

  // ---------------------------------------------------------------------------
  // Capture register
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_d = cap_q;
    if (load && !hold) begin
      cap_d = value;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode with leading-zero blanking
  // ---------------------------------------------------------------------------
  // top_nz ends at the highest nonzero digit, or 0 when cap is all zero, so
  // digit 0 can never be blanked and a zero value still shows a single "0".
  always_comb begin
    top_nz = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cap_q[4*k +: 4] != 4'h0) begin
        top_nz = IDX_W'(k);
      end
    end
  end

  always_comb begin
    dec_all = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (blank_lz && (IDX_W'(k) > top_nz)) begin
        dec_all[7*k +: 7] = 7'h00;
      end else begin
        dec_all[7*k +: 7] = seg7_decode(cap_q[4*k +: 4]);
      end
    end
  end

  // Compare-select rather than a variable index, so a non-power-of-two DIGITS
  // never reads past the end of dec_all.
  always_comb begin
    dig_sel = 7'h00;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        dig_sel = dec_all[7*k +: 7];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  always_comb begin
    sc_wrap = (sc_q == SC_LAST);
    sc_d    = sc_wrap ? '0 : sc_q + SC_W'(1);
    idx_d   = idx_q;
    if (sc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // Registered, so the pulse lands on the cycle after the last wrap.
    frame_d = sc_wrap && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sc_q    <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers (pin polarity applied here)
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d  = '0;
    seg_d = 7'h00;
    if (sc_q >= SC_BLANK) begin
      for (int k = 0; k < DIGITS; k++) begin
        an_d[k] = (idx_q == IDX_W'(k));
      end
      seg_d = dig_sel;
    end
    all_d = dec_all;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      all_q <= ALL_OFF;
    end else begin
      seg_q <= seg_d ^ SEG_OFF;
      an_q  <= an_d ^ AN_OFF;
      all_q <= all_d ^ ALL_OFF;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign segs_all   = all_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Three instances share one stimulus bus:
//   A: DIGITS=8, SCAN_DIV=16, BLANK_CYC=4, active-high pins
//   B: DIGITS=4, SCAN_DIV=16, BLANK_CYC=4, active-low pins
//   C: DIGITS=1, SCAN_DIV=4,  BLANK_CYC=1, active-high pins
// A reference model runs alongside; each clock it queues the outputs every
// instance must show after the next edge, and the queue is drained and
// compared once that edge has passed.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic        clk      = 1'b0;
  logic        clr      = 1'b0;
  logic        load     = 1'b0;
  logic        hold     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] value    = 32'h0;

  always #5 clk = ~clk;

  logic [6:0]  seg_a, seg_b, seg_c;
  logic [7:0]  an_a;
  logic [3:0]  an_b;
  logic [0:0]  an_c;
  logic [55:0] sa_a;
  logic [27:0] sa_b;
  logic [6:0]  sa_c;
  logic        fd_a, fd_b, fd_c;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(16), .BLANK_CYC(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .clr(clr), .value(value), .load(load), .hold(hold),
    .blank_lz(blank_lz), .seg(seg_a), .an(an_a), .segs_all(sa_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(16), .BLANK_CYC(4), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .clr(clr), .value(value[15:0]), .load(load), .hold(hold),
    .blank_lz(blank_lz), .seg(seg_b), .an(an_b), .segs_all(sa_b), .frame_done(fd_b)
  );

  seg_scan_ctrl #(.DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .clr(clr), .value(value[3:0]), .load(load), .hold(hold),
    .blank_lz(blank_lz), .seg(seg_c), .an(an_c), .segs_all(sa_c), .frame_done(fd_c)
  );

  int    p_d   [3] = '{8, 4, 1};
  int    p_div [3] = '{16, 16, 4};
  int    p_bl  [3] = '{4, 4, 1};
  bit    p_al  [3] = '{1'b0, 1'b1, 1'b0};
  string p_nm  [3] = '{"A", "B", "C"};

  int          m_sc  [3];
  int          m_idx [3];
  logic [63:0] m_cap [3];

  typedef struct {
    int          due;
    int          inst;
    logic [63:0] sa;
    logic [15:0] an;
    logic [6:0]  seg;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Segments of digit k of a d-digit value, leading-zero blanking applied.
  function automatic logic [6:0] dig_seg(input logic [63:0] cap, input int d,
                                         input int k, input logic blz);
    int hi;
    hi = 0;
    for (int j = d - 1; j >= 0; j--) begin
      if (cap[4*j +: 4] != 4'h0) begin
        hi = j;
        break;
      end
    end
    if (blz && (k > hi)) return 7'h00;
    return seg7(cap[4*k +: 4]);
  endfunction

  // Queue what each instance must show after the coming edge, advance the
  // model across that edge, then compare everything that has come due.
  task automatic tick();
    exp_t        e;
    logic [63:0] sa;
    logic [15:0] an;
    logic [6:0]  sg;
    logic [63:0] a_sa;
    logic [15:0] a_an;
    logic [6:0]  a_seg;
    logic        a_fd;
    for (int i = 0; i < 3; i++) begin
      e.due  = cyc + 1;
      e.inst = i;
      if (clr) begin
        e.sa     = p_al[i] ? wmask(7 * p_d[i]) : 64'd0;
        e.an     = p_al[i] ? 16'(wmask(p_d[i])) : 16'd0;
        e.seg    = p_al[i] ? 7'h7F : 7'h00;
        e.fd     = 1'b0;
        m_sc[i]  = 0;
        m_idx[i] = 0;
        m_cap[i] = 64'd0;
      end else begin
        sa = 64'd0;
        for (int k = 0; k < p_d[i]; k++) begin
          sa[7*k +: 7] = dig_seg(m_cap[i], p_d[i], k, blank_lz);
        end
        an = 16'd0;
        sg = 7'h00;
        if (m_sc[i] >= p_bl[i]) begin
          an[m_idx[i]] = 1'b1;
          sg = dig_seg(m_cap[i], p_d[i], m_idx[i], blank_lz);
        end
        if (p_al[i]) begin
          sa = ~sa & wmask(7 * p_d[i]);
          an = ~an & 16'(wmask(p_d[i]));
          sg = ~sg;
        end
        e.sa  = sa;
        e.an  = an;
        e.seg = sg;
        e.fd  = (m_sc[i] == p_div[i] - 1) && (m_idx[i] == p_d[i] - 1);
        if (load && !hold) m_cap[i] = 64'(value) & wmask(4 * p_d[i]);
        if (m_sc[i] == p_div[i] - 1) begin
          m_sc[i]  = 0;
          m_idx[i] = (m_idx[i] == p_d[i] - 1) ? 0 : m_idx[i] + 1;
        end else begin
          m_sc[i]++;
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.inst)
        0:       begin a_sa = 64'(sa_a); a_an = 16'(an_a); a_seg = seg_a; a_fd = fd_a; end
        1:       begin a_sa = 64'(sa_b); a_an = 16'(an_b); a_seg = seg_b; a_fd = fd_b; end
        default: begin a_sa = 64'(sa_c); a_an = 16'(an_c); a_seg = seg_c; a_fd = fd_c; end
      endcase
      chk({p_nm[e.inst], ".segs_all"},   a_sa,        e.sa);
      chk({p_nm[e.inst], ".an"},         64'(a_an),   64'(e.an));
      chk({p_nm[e.inst], ".seg"},        64'(a_seg),  64'(e.seg));
      chk({p_nm[e.inst], ".frame_done"}, 64'(a_fd),   64'(e.fd));
    end
  endtask

  initial begin
    int nb;
    int nc;
    bit found;

    // Reset state, asynchronous: no clock edge has happened yet.
    #1 clr = 1'b1;
    #1;
    chk("rst.A.seg",        64'(seg_a), 64'd0);
    chk("rst.A.an",         64'(an_a),  64'd0);
    chk("rst.A.segs_all",   64'(sa_a),  64'd0);
    chk("rst.A.frame_done", 64'(fd_a),  64'd0);
    chk("rst.B.an",         64'(an_b),  64'hF);
    chk("rst.B.seg",        64'(seg_b), 64'h7F);
    chk("rst.B.segs_all",   64'(sa_b),  64'hFFF_FFFF);
    tick();
    tick();
    clr = 1'b0;

    // Scan sequence from reset release on B: 4 dark, 12 on digit 0, 4 dark,
    // 12 on digit 1 (active-low pins).
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1 || k == 4)   chk("B.an.blank0", 64'(an_b), 64'hF);
      if (k == 5 || k == 16)  chk("B.an.dig0",   64'(an_b), 64'hE);
      if (k == 17 || k == 20) chk("B.an.blank1", 64'(an_b), 64'hF);
      if (k == 21 || k == 32) chk("B.an.dig1",   64'(an_b), 64'hD);
    end

    // Load with two-cycle latency to segs_all.
    value = 32'h0123_ABCD;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    chk("A.load.dig0", 64'(sa_a[6:0]),   64'h5E);
    chk("A.load.dig3", 64'(sa_a[27:21]), 64'h77);
    chk("A.load.dig7", 64'(sa_a[55:49]), 64'h3F);
    for (int k = 0; k < 20; k++) tick();

    // Leading-zero blanking.
    blank_lz = 1'b1;
    value    = 32'h0000_00F0;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    tick();
    chk("A.blz.upper", 64'(sa_a[55:14]), 64'd0);
    chk("A.blz.dig1",  64'(sa_a[13:7]),  64'h71);
    chk("A.blz.dig0",  64'(sa_a[6:0]),   64'h3F);
    chk("B.blz.upper", 64'(sa_b[27:14]), 64'h3FFF);
    for (int k = 0; k < 10; k++) tick();

    // hold blocks load; releasing hold alone does not capture.
    hold  = 1'b1;
    load  = 1'b1;
    value = 32'h1111_2222;
    tick();
    tick();
    chk("A.hold.ignore", 64'(sa_a[13:7]), 64'h71);
    load = 1'b0;
    hold = 1'b0;
    tick();
    tick();
    chk("A.hold.release", 64'(sa_a[13:7]), 64'h71);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("A.hold.resume0", 64'(sa_a[6:0]),   64'h5B);
    chk("A.hold.resume7", 64'(sa_a[55:49]), 64'h06);

    // blank_lz toggled mid-slot.
    value = 32'h0000_0030;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    blank_lz = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    blank_lz = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Frame rate: B frames every 64 clocks, C every 4.
    blank_lz = 1'b0;
    value    = 32'h0000_4321;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    nb = 0;
    nc = 0;
    for (int k = 0; k < 128; k++) begin
      tick();
      if (fd_b) nb++;
      if (fd_c) nc++;
    end
    chk("B.frames", 64'(nb), 64'd2);
    chk("C.frames", 64'(nc), 64'd32);

    // clr just before B's frame end: immediate inactive pins, no pulse.
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_sc[1] == 15 && m_idx[1] == 3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("B.find_frame_end", 64'(found), 64'd1);
    clr = 1'b1;
    #1;
    chk("clr.B.an",       64'(an_b),  64'hF);
    chk("clr.B.seg",      64'(seg_b), 64'h7F);
    chk("clr.B.fd",       64'(fd_b),  64'd0);
    chk("clr.A.segs_all", 64'(sa_a),  64'd0);
    tick();
    chk("clr.B.no_fd", 64'(fd_b), 64'd0);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("clr.B.restart_dig0", 64'(an_b), 64'hE);
    for (int k = 0; k < 40; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
